bram_mac_sequencer: RTL and testbench

//  Initiator side of the BRAM shift-add multiplier interface.
//  - Walks TAPS coefficient/operand pairs out of block RAM.
//  - Drives each pair into the external shift-add multiplier.
//  - Takes back the multiplier's packed two-lane magnitudes and sign.
//  - Accumulates two signed lane sums (a = operand[15:8], b = operand[7:0]).
//  - Hands the sums to the backend through a valid/ready result port.

---
 rtl/bram_mac_if.sv | 38 +++
 rtl/bram_mac_sequencer.sv | 124 ++++++++++++
 tb/tb_bram_mac_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_mac_if.sv
// Bundle of the sequencer's job, RAM, multiplier and result signals.
// The master modport is the sequencer's view; slave is the environment's view.
interface bram_mac_if #(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned ACC_W  = 20
);
   logic              start;
   logic              start_ready;
   logic [ADDR_W-1:0] base_addr;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [5:0]        coef_data;
   logic [15:0]       opnd_data;
   logic [15:0]       mult_operand;
   logic [5:0]        mult_coef;
   logic [15:0]       mult_a;
   logic [15:0]       mult_b;
   logic              mult_sign;
   logic              res_valid;
   logic              res_ready;
   logic [ACC_W-1:0]  res_a;
   logic [ACC_W-1:0]  res_b;
   logic              ovf_a;
   logic              ovf_b;
   logic              busy;

   modport master (
      input  start, base_addr, coef_data, opnd_data, mult_a, mult_b, mult_sign, res_ready,
      output start_ready, rd_en, rd_addr, mult_operand, mult_coef, res_valid, res_a, res_b,
             ovf_a, ovf_b, busy
   );

   modport slave (
      output start, base_addr, coef_data, opnd_data, mult_a, mult_b, mult_sign, res_ready,
      input  start_ready, rd_en, rd_addr, mult_operand, mult_coef, res_valid, res_a, res_b,
             ovf_a, ovf_b, busy
   );
endinterface

// File: rtl/bram_mac_sequencer.sv
// Walks TAPS coefficient/operand pairs out of block RAM through an external shift-add
// multiplier and accumulates two saturating signed lane sums for a valid/ready backend.
module bram_mac_sequencer #(
   parameter int unsigned TAPS   = 8,
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned ACC_W  = 20
) (
   input logic        clk,
   input logic        reset,
   bram_mac_if.master bus
);
   localparam int unsigned K_W = (TAPS > 1) ? $clog2(TAPS) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e            state_q, state_d;
   logic [K_W-1:0]    k_q, k_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              clear;
   logic              issue;
   logic              v1_q, v2_q;
   logic [15:0]       opnd_q;
   logic [5:0]        coef_q;
   logic [ACC_W-1:0]  acc_a_q, acc_b_q;
   logic              ovf_a_q, ovf_b_q;
   logic [ACC_W:0]    add_a, add_b;

   // Returns {saturated, result}; sum formed one bit wider than the accumulator.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                              input logic [15:0] mag, input logic neg);
      logic [ACC_W:0] term;
      logic [ACC_W:0] sum;
      term = {{(ACC_W - 15){1'b0}}, mag};
      if (neg) term = -term;
      sum = {acc[ACC_W-1], acc} + term;
      if (sum[ACC_W] != sum[ACC_W-1]) begin
         return {1'b1, sum[ACC_W], {(ACC_W - 1){~sum[ACC_W]}}};
      end
      return {1'b0, sum[ACC_W-1:0]};
   endfunction

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      base_d  = base_q;
      clear   = 1'b0;
      issue   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StRun;
               base_d  = bus.base_addr;
               k_d     = '0;
               clear   = 1'b1;
            end
         end
         StRun: begin
            issue = 1'b1;
            if (k_q == K_W'(TAPS - 1)) state_d = StDrain;
            else k_d = k_q + K_W'(1);
         end
         StDrain: begin
            // No read in flight behind v1, so v2's last add lands on this same edge.
            if (!v1_q) state_d = StDone;
         end
         StDone: begin
            if (bus.res_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign add_a = sat_add(acc_a_q, bus.mult_a, bus.mult_sign);
   assign add_b = sat_add(acc_b_q, bus.mult_b, bus.mult_sign);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         k_q     <= '0;
         base_q  <= '0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         opnd_q  <= '0;
         coef_q  <= '0;
         acc_a_q <= '0;
         acc_b_q <= '0;
         ovf_a_q <= 1'b0;
         ovf_b_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         base_q  <= base_d;
         v1_q    <= issue;
         v2_q    <= v1_q;
         if (v1_q) begin
            opnd_q <= bus.opnd_data;
            coef_q <= bus.coef_data;
         end
         if (clear) begin
            acc_a_q <= '0;
            acc_b_q <= '0;
            ovf_a_q <= 1'b0;
            ovf_b_q <= 1'b0;
         end else if (v2_q) begin
            acc_a_q <= add_a[ACC_W-1:0];
            acc_b_q <= add_b[ACC_W-1:0];
            ovf_a_q <= ovf_a_q | add_a[ACC_W];
            ovf_b_q <= ovf_b_q | add_b[ACC_W];
         end
      end
   end

   assign bus.start_ready  = (state_q == StIdle);
   assign bus.busy         = (state_q != StIdle);
   assign bus.res_valid    = (state_q == StDone);
   assign bus.rd_en        = issue;
   assign bus.rd_addr      = issue ? (base_q + ADDR_W'(k_q)) : '0;
   assign bus.mult_operand = opnd_q;
   assign bus.mult_coef    = coef_q;
   assign bus.res_a        = acc_a_q;
   assign bus.res_b        = acc_b_q;
   assign bus.ovf_a        = ovf_a_q;
   assign bus.ovf_b        = ovf_b_q;
endmodule

// File: tb/tb_bram_mac_sequencer.sv
// Bench for bram_mac_sequencer: a RAM and multiplier emulation, a job-level model of the
// sums and timing, a per-cycle compare process, and directed jobs with literal checks.
module tb_bram_mac_sequencer;
   logic clk;
   logic reset;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   bram_mac_if #(.ADDR_W(3), .ACC_W(20)) if0 ();
   bram_mac_if #(.ADDR_W(3), .ACC_W(17)) if1 ();

   bram_mac_sequencer #(.TAPS(8), .ADDR_W(3), .ACC_W(20)) u0 (
      .clk(clk), .reset(reset), .bus(if0)
   );
   bram_mac_sequencer #(.TAPS(12), .ADDR_W(3), .ACC_W(17)) u1 (
      .clk(clk), .reset(reset), .bus(if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [5:0]  mem_c [8];
   logic [15:0] mem_o [8];
   logic [2:0]  addr_log [$];

   int     taps_p [2] = '{8, 12};
   int     accw_p [2] = '{20, 17};
   int     s_cyc  [2] = '{0, 0};
   int     base   [2] = '{0, 0};
   bit     active [2] = '{0, 0};
   longint exp_ra [2] = '{0, 0};
   longint exp_rb [2] = '{0, 0};
   bit     exp_oa [2] = '{0, 0};
   bit     exp_ob [2] = '{0, 0};

   // Coefficient codes used by the multiplier emulation.
   function automatic int coef_val(input logic [5:0] c);
      case (c)
         6'b000001: return 1;
         6'b111111: return -35;
         6'b001111: return 49;
         default:   return int'($signed(c));
      endcase
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   assign if0.mult_sign = coef_val(if0.mult_coef) < 0;
   assign if0.mult_a = 16'(iabs(coef_val(if0.mult_coef)) * int'(if0.mult_operand[15:8]));
   assign if0.mult_b = 16'(iabs(coef_val(if0.mult_coef)) * int'(if0.mult_operand[7:0]));
   assign if1.mult_sign = coef_val(if1.mult_coef) < 0;
   assign if1.mult_a = 16'(iabs(coef_val(if1.mult_coef)) * int'(if1.mult_operand[15:8]));
   assign if1.mult_b = 16'(iabs(coef_val(if1.mult_coef)) * int'(if1.mult_operand[7:0]));

   always @(posedge clk) begin
      if (if0.rd_en) begin
         if0.coef_data <= mem_c[if0.rd_addr];
         if0.opnd_data <= mem_o[if0.rd_addr];
      end
      if (if1.rd_en) begin
         if1.coef_data <= mem_c[if1.rd_addr];
         if1.opnd_data <= mem_o[if1.rd_addr];
      end
   end

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Job-level model: signed products summed with saturation after every tap.
   function automatic void model(input int n, input int accw, input int b,
                                 output longint ra, output longint rb,
                                 output bit oa, output bit ob);
      longint hi, lo, cv;
      int     ad;
      hi = (longint'(1) <<< (accw - 1)) - 1;
      lo = -hi - 1;
      ra = 0; rb = 0; oa = 0; ob = 0;
      for (int k = 0; k < n; k++) begin
         ad = (b + k) % 8;
         cv = longint'(coef_val(mem_c[ad]));
         ra += cv * longint'(mem_o[ad][15:8]);
         rb += cv * longint'(mem_o[ad][7:0]);
         if (ra > hi) begin ra = hi; oa = 1; end
         else if (ra < lo) begin ra = lo; oa = 1; end
         if (rb > hi) begin rb = hi; ob = 1; end
         else if (rb < lo) begin rb = lo; ob = 1; end
      end
   endfunction

   task automatic cmp(input int i, input logic rd_en, input logic [2:0] rd_addr,
                      input logic res_valid, input logic start_ready, input logic busy,
                      input logic signed [63:0] ra, input logic signed [63:0] rb,
                      input logic oa, input logic ob);
      bit    e_busy, e_rd, e_valid;
      string t;
      t = $sformatf("u%0d c%0d", i, cyc);
      e_busy  = active[i] && (cyc > s_cyc[i]);
      e_rd    = e_busy && (cyc <= s_cyc[i] + taps_p[i]);
      e_valid = e_busy && (cyc >= s_cyc[i] + taps_p[i] + 3);
      chk({t, " rd_en"}, rd_en, e_rd);
      chk({t, " busy"}, busy, e_busy);
      chk({t, " start_ready"}, start_ready, !e_busy);
      chk({t, " res_valid"}, res_valid, e_valid);
      if (e_rd && rd_en) begin
         chk({t, " rd_addr"}, rd_addr, (base[i] + cyc - s_cyc[i] - 1) % 8);
         if (i == 0) addr_log.push_back(rd_addr);
      end
      if (e_valid) begin
         chk({t, " res_a"}, ra, exp_ra[i]);
         chk({t, " res_b"}, rb, exp_rb[i]);
         chk({t, " ovf_a"}, oa, exp_oa[i]);
         chk({t, " ovf_b"}, ob, exp_ob[i]);
      end
   endtask

   always @(negedge clk) begin
      cmp(0, if0.rd_en, if0.rd_addr, if0.res_valid, if0.start_ready, if0.busy,
          $signed(if0.res_a), $signed(if0.res_b), if0.ovf_a, if0.ovf_b);
      cmp(1, if1.rd_en, if1.rd_addr, if1.res_valid, if1.start_ready, if1.busy,
          $signed(if1.res_a), $signed(if1.res_b), if1.ovf_a, if1.ovf_b);
   end

   task automatic set_start(input int i, input logic v, input logic [2:0] b);
      if (i == 0) begin if0.start = v; if0.base_addr = b; end
      else begin if1.start = v; if1.base_addr = b; end
   endtask

   task automatic set_ready(input int i, input logic v);
      if (i == 0) if0.res_ready = v;
      else if1.res_ready = v;
   endtask

   function automatic logic get_valid(input int i);
      return (i == 0) ? if0.res_valid : if1.res_valid;
   endfunction

   task automatic fill(input int mode);
      for (int k = 0; k < 8; k++) begin
         case (mode)
            1: begin mem_c[k] = 6'b000001; mem_o[k] = 16'h0102; end
            2: begin
               mem_c[k] = (k == 0) ? 6'b111111 : 6'b000000;
               mem_o[k] = (k == 0) ? 16'hFF01 : 16'hFFFF;
            end
            3: begin mem_c[k] = 6'(k * 5 + 3); mem_o[k] = 16'(k * 4660 + 291); end
            default: begin mem_c[k] = 6'b001111; mem_o[k] = 16'hFF00; end
         endcase
      end
   endtask

   task automatic start_job(input int i, input int b);
      model(taps_p[i], accw_p[i], b, exp_ra[i], exp_rb[i], exp_oa[i], exp_ob[i]);
      base[i] = b;
      @(negedge clk);
      set_start(i, 1'b1, 3'(b));
      s_cyc[i]  = cyc;
      active[i] = 1'b1;
      @(negedge clk);
      set_start(i, 1'b0, 3'(b));
   endtask

   task automatic wait_done(input int i);
      int n = 0;
      while (!get_valid(i) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("u%0d res_valid arrives", i), get_valid(i), 1'b1);
   endtask

   // Holds off the backend for 'hold' cycles, pulsing a stray start, then hands shakes.
   task automatic finish_job(input int i, input int hold);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         set_start(i, k == 1, 3'd5);
      end
      @(negedge clk);
      set_start(i, 1'b0, 3'd0);
      set_ready(i, 1'b1);
      @(posedge clk);
      #1;
      active[i] = 1'b0;
      set_ready(i, 1'b0);
   endtask

   task automatic check_idle0(input string tag);
      chk({tag, " rd_en"}, if0.rd_en, 1'b0);
      chk({tag, " rd_addr"}, if0.rd_addr, 3'd0);
      chk({tag, " res_valid"}, if0.res_valid, 1'b0);
      chk({tag, " busy"}, if0.busy, 1'b0);
      chk({tag, " start_ready"}, if0.start_ready, 1'b1);
      chk({tag, " res_a"}, if0.res_a, 20'd0);
      chk({tag, " res_b"}, if0.res_b, 20'd0);
      chk({tag, " ovf"}, {if0.ovf_a, if0.ovf_b}, 2'b00);
      chk({tag, " mult_operand"}, if0.mult_operand, 16'd0);
      chk({tag, " mult_coef"}, if0.mult_coef, 6'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      set_start(0, 1'b0, 3'd0);
      set_start(1, 1'b0, 3'd0);
      set_ready(0, 1'b0);
      set_ready(1, 1'b0);
      fill(1);
      @(negedge clk);
      check_idle0("reset");
      chk("u1 reset start_ready", if1.start_ready, 1'b1);
      chk("u1 reset res_a", if1.res_a, 17'd0);
      @(negedge clk);
      reset = 1'b0;

      // Basic job: unit coefficients, timing pinned to cycle 11.
      fill(1);
      start_job(0, 0);
      wait_done(0);
      chk("t1 latency", cyc - s_cyc[0], 11);
      chk("t1 res_a", $signed(if0.res_a), 8);
      chk("t1 res_b", $signed(if0.res_b), 16);
      chk("t1 ovf", {if0.ovf_a, if0.ovf_b}, 2'b00);
      finish_job(0, 0);

      // Negative products; res_ready toggled while running has no effect.
      fill(2);
      start_job(0, 0);
      for (int k = 0; k < 3; k++) begin
         set_ready(0, 1'b1);
         @(negedge clk);
      end
      set_ready(0, 1'b0);
      wait_done(0);
      chk("t2 res_a", $signed(if0.res_a), -8925);
      chk("t2 res_b", $signed(if0.res_b), -35);
      finish_job(0, 0);

      // Address wrap from base 6; backend stalls with a stray start in DONE.
      fill(3);
      addr_log.delete();
      start_job(0, 6);
      wait_done(0);
      chk("t3 addr count", addr_log.size(), 8);
      if (addr_log.size() >= 4) begin
         chk("t3 addr0", addr_log[0], 3'd6);
         chk("t3 addr1", addr_log[1], 3'd7);
         chk("t3 addr2", addr_log[2], 3'd0);
         chk("t3 addr3", addr_log[3], 3'd1);
      end
      finish_job(0, 5);
      chk("t5 start_ready after handshake", if0.start_ready, 1'b1);
      chk("t5 busy after handshake", if0.busy, 1'b0);

      // Narrow accumulator saturates lane a over 12 wrapped taps.
      fill(4);
      start_job(1, 0);
      wait_done(1);
      chk("t4 res_a", $signed(if1.res_a), 65535);
      chk("t4 ovf_a", if1.ovf_a, 1'b1);
      chk("t4 res_b", $signed(if1.res_b), 0);
      chk("t4 ovf_b", if1.ovf_b, 1'b0);
      finish_job(1, 0);

      // Reset in cycle 4 of a job aborts it; a rerun behaves normally.
      fill(1);
      start_job(0, 0);
      while (cyc < s_cyc[0] + 4) @(negedge clk);
      #2;
      reset = 1'b1;
      active[0] = 1'b0;
      #1;
      check_idle0("t6 mid-job reset");
      @(negedge clk);
      #2;
      reset = 1'b0;
      start_job(0, 0);
      wait_done(0);
      chk("t6 rerun res_a", $signed(if0.res_a), 8);
      chk("t6 rerun res_b", $signed(if0.res_b), 16);
      finish_job(0, 0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
